tick_generator: RTL and testbench

Parametrised multi-channel rate generator: the next generation of the clock's fixed five-rate divider. It derives `NUM_CH` independent rates from the single system clock `clk`. For each rate it produces a 50 %-duty square-wave enable and a one-cycle tick pulse. Global pause, per-channel enable and synchronous phase realignment are included. It sits at the top of the clock datapath and feeds seconds counting, blink and display-scan logic.

---
 rtl/tick_generator.sv | 73 +++++++
 tb/tb_tick_generator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// Multi-channel rate generator. Each channel divides clk into a 50 % square
// wave plus a one-cycle tick on every rising edge of that wave.
module tick_generator #(
  parameter int unsigned          CLK_HZ = 50_000_000,
  parameter int unsigned          NUM_CH = 5,
  parameter logic [32*NUM_CH-1:0] CH_HZ  = {32'd100, 32'd50, 32'd20, 32'd5, 32'd1}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] tick
);

  if (NUM_CH < 1) begin : g_err_num_ch
    $error("tick_generator: NUM_CH must be at least 1");
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam longint unsigned HZ       = 64'(CH_HZ[32*gi +: 32]);
      localparam longint unsigned HALF_RAW = (HZ == 64'd0) ? 64'd0 : 64'(CLK_HZ) / (64'd2 * HZ);
      // Clamped so a bad rate still elaborates far enough to report its error.
      localparam int unsigned     HALF     = (HALF_RAW < 64'd1) ? 32'd1 : 32'(HALF_RAW);
      localparam int              W        = (HALF > 1) ? $clog2(HALF) : 1;
      localparam logic [W-1:0]    TERM     = W'(HALF - 1);

      if (HZ == 64'd0) begin : g_err_zero
        $error("tick_generator: channel %0d has a rate of 0 Hz", gi);
      end else if (64'd2 * HZ > 64'(CLK_HZ)) begin : g_err_fast
        $error("tick_generator: channel %0d rate exceeds CLK_HZ/2", gi);
      end

      logic [W-1:0] r_cnt;
      logic         r_sq;
      logic         r_tick;
      logic         w_clr;
      logic         w_term;

      assign w_clr  = sync_clr | ~ch_en[gi];
      assign w_term = (r_cnt == TERM);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt  <= '0;
          r_sq   <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_clr) begin
          r_cnt  <= '0;
          r_sq   <= 1'b0;
          r_tick <= 1'b0;
        end else if (!en) begin
          r_tick <= 1'b0;
        end else if (w_term) begin
          // Tick only on the low-to-high half of the toggle.
          r_cnt  <= '0;
          r_sq   <= ~r_sq;
          r_tick <= ~r_sq;
        end else begin
          r_cnt  <= r_cnt + W'(1);
          r_tick <= 1'b0;
        end
      end

      assign sq[gi]   = r_sq;
      assign tick[gi] = r_tick;
    end
  endgenerate

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: phase-count reference model checked every cycle,
// plus literal edge-number expectations from the test plan.
module tb_tick_generator;

  localparam int unsigned NCH = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NCH-1:0] ch_en;
  logic           sync_clr;
  logic [NCH-1:0] sq;
  logic [NCH-1:0] tick;

  int checks = 0;
  int errors = 0;

  tick_generator #(
    .CLK_HZ(1000),
    .NUM_CH(NCH),
    .CH_HZ ({32'd500, 32'd250, 32'd100, 32'd5, 32'd1})
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ch_en   (ch_en),
    .sync_clr(sync_clr),
    .sq      (sq),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  // Model: each channel tracks its position within the 2*HALF period.
  // sq is high for the second half; tick marks the first cycle of it.
  const int HALF_M [NCH] = '{500, 100, 5, 2, 1};
  int       ph     [NCH];
  logic [NCH-1:0] m_sq;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] prev_tick;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst || sync_clr || !ch_en[i]) begin
        ph[i]     = 0;
        m_sq[i]   = 1'b0;
        m_tick[i] = 1'b0;
      end else if (!en) begin
        m_tick[i] = 1'b0;
      end else begin
        ph[i]     = (ph[i] + 1) % (2 * HALF_M[i]);
        m_sq[i]   = (ph[i] >= HALF_M[i]);
        m_tick[i] = (ph[i] == HALF_M[i]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
    $display("check %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_sq", 32'(sq), 32'(m_sq));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("tick_back_to_back", 32'(tick & prev_tick), 32'd0);
      prev_tick = tick;
    end else begin
      prev_tick = '0;
    end
  end

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    lit("async_rst_sq", 32'(sq), 32'd0);
    lit("async_rst_tick", 32'(tick), 32'd0);
    en       = 1'b1;
    ch_en    = '1;
    sync_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Edge e is the e-th rising edge after reset release; inputs driven after
  // edge e are first sampled at edge e+1.
  task automatic run(input int sc, input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      case (sc)
        0: begin
          if (e == 1)    lit("ref_t4_e1", 32'(tick[4]), 32'd1);
          if (e == 2)    lit("ref_t4_e2", 32'(tick[4]), 32'd0);
          if (e == 2)    lit("ref_t3_e2", 32'(tick[3]), 32'd1);
          if (e == 4)    lit("ref_t2_e4", 32'(tick[2]), 32'd0);
          if (e == 5)    lit("ref_t2_e5", 32'(tick[2]), 32'd1);
          if (e == 6)    lit("ref_t3_e6", 32'(tick[3]), 32'd1);
          if (e == 15)   lit("ref_t2_e15", 32'(tick[2]), 32'd1);
          if (e == 100)  lit("ref_t1_e100", 32'(tick[1]), 32'd1);
          if (e == 499)  lit("ref_sq0_e499", 32'(sq[0]), 32'd0);
          if (e == 500)  lit("ref_t0_e500", 32'(tick[0]), 32'd1);
          if (e == 999)  lit("ref_sq0_e999", 32'(sq[0]), 32'd1);
          if (e == 1000) lit("ref_sq0_e1000", 32'(sq[0]), 32'd0);
          if (e == 1500) lit("ref_t0_e1500", 32'(tick[0]), 32'd1);
        end
        1: begin
          if (e == 5)  lit("pause_t2_e5", 32'(tick[2]), 32'd0);
          if (e == 7)  lit("pause_tick_e7", 32'(tick), 32'd0);
          if (e == 12) lit("pause_t2_e12", 32'(tick[2]), 32'd1);
          if (e == 3)  en = 1'b0;
          if (e == 10) en = 1'b1;
        end
        2: begin
          if (e == 15)  lit("chclr_t2_e15", 32'(tick[2]), 32'd1);
          if (e == 55)  lit("chclr_sq1_e55", 32'(sq[1]), 32'd0);
          if (e == 100) lit("chclr_t1_e100", 32'(tick[1]), 32'd0);
          if (e == 160) lit("chclr_t1_e160", 32'(tick[1]), 32'd1);
          if (e == 50)  ch_en[1] = 1'b0;
          if (e == 60)  ch_en[1] = 1'b1;
        end
        3: begin
          if (e == 38) lit("sync_sq_e38", 32'(sq), 32'd0);
          if (e == 38) lit("sync_tick_e38", 32'(tick), 32'd0);
          if (e == 39) lit("sync_t4_e39", 32'(tick[4]), 32'd1);
          if (e == 42) lit("sync_t2_e42", 32'(tick[2]), 32'd0);
          if (e == 43) lit("sync_t2_e43", 32'(tick[2]), 32'd1);
          if (e == 37) sync_clr = 1'b1;
          if (e == 38) sync_clr = 1'b0;
        end
        4: begin
          if (e == 250) lit("midrst_sq3_e250", 32'(sq[3]), 32'd1);
        end
        default: begin
          en       = ($urandom_range(0, 9) != 0);
          ch_en    = NCH'($urandom) | NCH'($urandom);
          sync_clr = ($urandom_range(0, 49) == 0);
        end
      endcase
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    ch_en    = '1;
    sync_clr = 1'b0;
    prev_tick = '0;
    #12;
    lit("reset_sq", 32'(sq), 32'd0);
    lit("reset_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 1510);
    async_reset();
    run(1, 20);
    async_reset();
    run(2, 170);
    async_reset();
    run(3, 50);
    async_reset();
    run(4, 250);
    async_reset();
    run(0, 20);
    async_reset();
    run(5, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
